// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO timer: register offsets, CTRL/STATUS bit
// positions and the read-FSM state encoding.
package mmio_pkg;

    localparam int BUS_W = 16;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PRESCALE = 3'd1;
    localparam logic [2:0] ADDR_RELOAD   = 3'd2;
    localparam logic [2:0] ADDR_COUNT    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_EXP = 0;
    localparam int STAT_RUN = 1;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/mmio_timer_if.sv
// CPU-side register bus of the MMIO timer; the CPU is the master and the
// timer is the slave.
interface mmio_timer_if;
    import mmio_pkg::*;

    logic             sel;
    logic [2:0]       addr;
    logic             ram_read;
    logic             ram_write;
    logic             ram_read_done;
    logic [BUS_W-1:0] ram_in;
    logic [BUS_W-1:0] ram_out;
    logic             ram_busy;
    logic             ram_ready;
    logic             timer_irq;

    modport master (
        output sel, addr, ram_read, ram_write, ram_read_done, ram_in,
        input  ram_out, ram_busy, ram_ready, timer_irq
    );

    modport slave (
        input  sel, addr, ram_read, ram_write, ram_read_done, ram_in,
        output ram_out, ram_busy, ram_ready, timer_irq
    );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running divider: counts 0..limit while enabled and pulses tick for the
// cycle in which the count sits at limit, then wraps to 0.
module timer_prescaler #(
    parameter int CNT_W = 16
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] limit,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    // >= rather than == so that lowering limit below the current count still wraps promptly
    assign w_wrap = (r_cnt >= limit);
    assign tick   = en && w_wrap;

    always_ff @(posedge cpu_clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_wrap) r_cnt <= '0;
            else        r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload, sticky
// expiry flag and a multi-cycle read path; writes complete in one cycle.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic         cpu_clk,
    input  logic         rst,
    mmio_timer_if.slave  bus
);

    logic             r_en;
    logic             r_auto;
    logic             r_ie;
    logic             r_exp;
    logic [CNT_W-1:0] r_prescale;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] r_count;

    rd_state_e        r_state;
    rd_state_e        w_next;
    logic [1:0]       r_wait;
    logic [BUS_W-1:0] r_snap;

    logic             w_wr;
    logic [CNT_W-1:0] w_wdata;
    logic             w_tick;
    logic             w_restart;
    logic             w_expire;
    logic [BUS_W-1:0] w_rdata;
    logic             w_busy;
    logic             w_ready;
    logic [BUS_W-1:0] w_out;

    assign w_wr      = bus.sel && bus.ram_write;
    assign w_wdata   = bus.ram_in[CNT_W-1:0];
    assign w_restart = w_wr && (bus.addr == ADDR_CTRL) && bus.ram_in[CTRL_EN] && !r_en;
    assign w_expire  = w_tick && (r_count == '0);

    timer_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .en      (r_en),
        .restart (w_restart),
        .limit   (r_prescale),
        .tick    (w_tick)
    );

    // Timer updates come first so a same-cycle CPU write overrides them; only EXP is set-dominant.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_ie       <= 1'b0;
            r_exp      <= 1'b0;
            r_prescale <= '0;
            r_reload   <= '0;
            r_count    <= '0;
        end else begin
            if (w_tick) begin
                if (r_count != '0)  r_count <= r_count - 1'b1;
                else if (r_auto)    r_count <= r_reload;
                else                r_en    <= 1'b0;
            end
            if (w_wr) begin
                case (bus.addr)
                    ADDR_CTRL: begin
                        r_en   <= bus.ram_in[CTRL_EN];
                        r_auto <= bus.ram_in[CTRL_AUTO];
                        r_ie   <= bus.ram_in[CTRL_IE];
                    end
                    ADDR_PRESCALE: r_prescale <= w_wdata;
                    ADDR_RELOAD:   r_reload   <= w_wdata;
                    ADDR_COUNT:    r_count    <= w_wdata;
                    ADDR_STATUS:   if (bus.ram_in[STAT_EXP]) r_exp <= 1'b0;
                    default: ;
                endcase
            end
            if (w_expire) r_exp <= 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            ADDR_CTRL: begin
                w_rdata[CTRL_EN]   = r_en;
                w_rdata[CTRL_AUTO] = r_auto;
                w_rdata[CTRL_IE]   = r_ie;
            end
            ADDR_PRESCALE: w_rdata[CNT_W-1:0] = r_prescale;
            ADDR_RELOAD:   w_rdata[CNT_W-1:0] = r_reload;
            ADDR_COUNT:    w_rdata[CNT_W-1:0] = r_count;
            ADDR_STATUS: begin
                w_rdata[STAT_EXP] = r_exp;
                w_rdata[STAT_RUN] = r_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) r_state <= RD_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_ready = 1'b1;
        w_out   = '0;
        case (r_state)
            RD_IDLE: if (bus.sel && bus.ram_read) w_next = RD_WAIT;
            RD_WAIT: begin
                w_busy  = 1'b1;
                w_ready = 1'b0;
                if (r_wait == 2'd0) w_next = RD_DONE;
            end
            RD_DONE: begin
                w_out = r_snap;
                if (bus.ram_read_done || !bus.sel) w_next = RD_IDLE;
            end
            default: w_next = RD_IDLE;
        endcase
    end

    // The snapshot freezes the addressed register at request time, so later writes cannot leak into it.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            r_wait <= 2'd0;
            r_snap <= '0;
        end else if (r_state == RD_IDLE && w_next == RD_WAIT) begin
            r_wait <= 2'(RD_LAT - 1);
            r_snap <= w_rdata;
        end else if (r_state == RD_WAIT && r_wait != 2'd0) begin
            r_wait <= r_wait - 2'd1;
        end
    end

    assign bus.ram_out   = w_out;
    assign bus.ram_busy  = w_busy;
    assign bus.ram_ready = w_ready;
    assign bus.timer_irq = r_exp && r_ie;

endmodule
